// File: rtl/eddy_sample_accumulator_pkg.sv
// Shared constants, FSM state type and helpers for the eddy sample accumulator.
package eddy_accum_pkg;

  localparam int DATA_W     = 18;
  localparam int MAX_LOG2_N = 4;
  localparam int ACC_W      = DATA_W + MAX_LOG2_N;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Requested exponents beyond the accumulator headroom fall back to the largest window.
  function automatic logic [2:0] clamp_log2(input logic [2:0] l2, input int max_l2);
    if (int'(l2) > max_l2) begin
      return 3'(max_l2);
    end
    return l2;
  endfunction

endpackage

// File: rtl/eddy_sample_accumulator_if.sv
// Result/handshake bus between the accumulator and the AXI register layer.
// Optional min/max fields exist only when EDDY_ACCUM_MINMAX_EN is defined.
interface eddy_result_if #(
  parameter int DATA_W     = eddy_accum_pkg::DATA_W,
  parameter int MAX_LOG2_N = eddy_accum_pkg::MAX_LOG2_N
);

  logic signed [DATA_W-1:0] avg_x;
  logic signed [DATA_W-1:0] avg_y;
  logic                     avg_valid;
  logic                     overrun;
  logic [MAX_LOG2_N:0]      sample_cnt;
  logic                     ack;
`ifdef EDDY_ACCUM_MINMAX_EN
  logic signed [DATA_W-1:0] min_x;
  logic signed [DATA_W-1:0] max_x;
  logic signed [DATA_W-1:0] min_y;
  logic signed [DATA_W-1:0] max_y;
`endif

  modport master (
    output avg_x, avg_y, avg_valid, overrun, sample_cnt,
`ifdef EDDY_ACCUM_MINMAX_EN
    output min_x, max_x, min_y, max_y,
`endif
    input  ack
  );

  modport slave (
    input  avg_x, avg_y, avg_valid, overrun, sample_cnt,
`ifdef EDDY_ACCUM_MINMAX_EN
    input  min_x, max_x, min_y, max_y,
`endif
    output ack
  );

endinterface

// File: rtl/eddy_sample_accumulator_channel.sv
// One axis of the accumulator: running sum, averaging shift and result register.
// Per-window min/max tracking is added when EDDY_ACCUM_MINMAX_EN is defined.
module eddy_accum_channel #(
  parameter int DATA_W     = eddy_accum_pkg::DATA_W,
  parameter int MAX_LOG2_N = eddy_accum_pkg::MAX_LOG2_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     zero_acc,
  input  logic                     add,
  input  logic                     fin,
`ifdef EDDY_ACCUM_MINMAX_EN
  input  logic                     first,
  output logic signed [DATA_W-1:0] min_val,
  output logic signed [DATA_W-1:0] max_val,
`endif
  input  logic [2:0]               log2,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] avg
);
  import eddy_accum_pkg::*;

  localparam int CH_ACC_W = DATA_W + MAX_LOG2_N;

  logic signed [CH_ACC_W-1:0] acc_reg;
  logic signed [CH_ACC_W-1:0] sample_ext;
  logic signed [CH_ACC_W-1:0] sum;
  logic signed [DATA_W-1:0]   avg_reg;

  assign sample_ext = {{MAX_LOG2_N{sample[DATA_W-1]}}, sample};
  assign sum        = acc_reg + sample_ext;
  assign avg        = avg_reg;

  // The final sample is folded in on the same edge the result is published.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      avg_reg <= '0;
    end else if (zero_acc) begin
      acc_reg <= '0;
    end else if (fin) begin
      avg_reg <= DATA_W'(sum >>> log2);
      acc_reg <= '0;
    end else if (add) begin
      acc_reg <= sum;
    end
  end

`ifdef EDDY_ACCUM_MINMAX_EN
  logic signed [DATA_W-1:0] run_min_reg, run_max_reg;
  logic signed [DATA_W-1:0] min_reg, max_reg;
  logic signed [DATA_W-1:0] cur_min, cur_max;

  assign cur_min = (first || sample < run_min_reg) ? sample : run_min_reg;
  assign cur_max = (first || sample > run_max_reg) ? sample : run_max_reg;
  assign min_val = min_reg;
  assign max_val = max_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min_reg <= '0;
      run_max_reg <= '0;
      min_reg     <= '0;
      max_reg     <= '0;
    end else if (!zero_acc && (add || fin)) begin
      run_min_reg <= cur_min;
      run_max_reg <= cur_max;
      if (fin) begin
        min_reg <= cur_min;
        max_reg <= cur_max;
      end
    end
  end
`endif

endmodule

// File: rtl/eddy_sample_accumulator.sv
// Block averager for SPI X/Y sample pairs with sticky valid/overrun handshake.
// Define EDDY_ACCUM_MINMAX_EN to also publish per-window min/max.
module eddy_sample_accumulator #(
  parameter int DATA_W     = eddy_accum_pkg::DATA_W,
  parameter int MAX_LOG2_N = eddy_accum_pkg::MAX_LOG2_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_in,
  input  logic signed [DATA_W-1:0] sensor_data_x,
  input  logic signed [DATA_W-1:0] sensor_data_y,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [2:0]               avg_log2,
  eddy_result_if.master            res
);
  import eddy_accum_pkg::*;

  state_t                   state_reg, state_next;
  logic                     done_s_reg, done_d_reg;
  logic signed [DATA_W-1:0] x_s_reg, y_s_reg;
  logic [2:0]               log2_eff, log2_prev_reg;
  logic [MAX_LOG2_N:0]      cnt_reg, cnt_next, last_idx;
  logic                     avg_valid_reg, avg_valid_next;
  logic                     overrun_reg, overrun_next;
  logic                     sample_ev, hold_idle, discard, take;
  logic                     final_s, add_s, zero_acc;

  // done_in and the data are sampled first, so the event is seen one edge
  // after done_in is first captured high and the result lands on the next edge.
  assign sample_ev = done_s_reg & ~done_d_reg;
  assign log2_eff  = clamp_log2(avg_log2, MAX_LOG2_N);
  assign last_idx  = (MAX_LOG2_N+1)'((32'd1 << log2_eff) - 32'd1);

  assign hold_idle = clear | ~enable | (state_reg != ACCUM);
  assign discard   = ~hold_idle & (log2_eff != log2_prev_reg) & (cnt_reg != '0);
  assign take      = ~hold_idle & ~discard & sample_ev;
  assign final_s   = take & (cnt_reg == last_idx);
  assign add_s     = take & ~final_s;
  assign zero_acc  = hold_idle | discard;

  always_comb begin
    state_next = (clear || !enable) ? IDLE : ACCUM;

    cnt_next = cnt_reg;
    if (zero_acc || final_s) begin
      cnt_next = '0;
    end else if (add_s) begin
      cnt_next = cnt_reg + 1'b1;
    end

    avg_valid_next = avg_valid_reg;
    overrun_next   = overrun_reg;
    if (clear) begin
      avg_valid_next = 1'b0;
      overrun_next   = 1'b0;
    end else if (final_s) begin
      avg_valid_next = 1'b1;
      if (avg_valid_reg && !res.ack) begin
        overrun_next = 1'b1;
      end
    end else if (res.ack) begin
      avg_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      done_s_reg    <= 1'b0;
      done_d_reg    <= 1'b0;
      x_s_reg       <= '0;
      y_s_reg       <= '0;
      log2_prev_reg <= '0;
      cnt_reg       <= '0;
      avg_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      done_s_reg    <= done_in;
      done_d_reg    <= done_s_reg;
      x_s_reg       <= sensor_data_x;
      y_s_reg       <= sensor_data_y;
      log2_prev_reg <= log2_eff;
      cnt_reg       <= cnt_next;
      avg_valid_reg <= avg_valid_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign res.avg_valid  = avg_valid_reg;
  assign res.overrun    = overrun_reg;
  assign res.sample_cnt = cnt_reg;

`ifdef EDDY_ACCUM_MINMAX_EN
  logic first_s;
  assign first_s = (cnt_reg == '0);
`endif

  eddy_accum_channel #(.DATA_W(DATA_W), .MAX_LOG2_N(MAX_LOG2_N)) u_chan_x (
    .clk      (clk),
    .rst      (rst),
    .zero_acc (zero_acc),
    .add      (add_s),
    .fin      (final_s),
`ifdef EDDY_ACCUM_MINMAX_EN
    .first    (first_s),
    .min_val  (res.min_x),
    .max_val  (res.max_x),
`endif
    .log2     (log2_eff),
    .sample   (x_s_reg),
    .avg      (res.avg_x)
  );

  eddy_accum_channel #(.DATA_W(DATA_W), .MAX_LOG2_N(MAX_LOG2_N)) u_chan_y (
    .clk      (clk),
    .rst      (rst),
    .zero_acc (zero_acc),
    .add      (add_s),
    .fin      (final_s),
`ifdef EDDY_ACCUM_MINMAX_EN
    .first    (first_s),
    .min_val  (res.min_y),
    .max_val  (res.max_y),
`endif
    .log2     (log2_eff),
    .sample   (y_s_reg),
    .avg      (res.avg_y)
  );

endmodule

// File: tb/tb_eddy_sample_accumulator.sv
// Self-checking bench for eddy_sample_accumulator: vector table, corner sequences, random windows.
module tb_eddy_sample_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done_in = 1'b0;
  logic [17:0] sensor_data_x = '0;
  logic [17:0] sensor_data_y = '0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  avg_log2 = '0;

  int checks = 0;
  int errors = 0;

  eddy_result_if res ();

  eddy_sample_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .done_in       (done_in),
    .sensor_data_x (sensor_data_x),
    .sensor_data_y (sensor_data_y),
    .enable        (enable),
    .clear         (clear),
    .avg_log2      (avg_log2),
    .res           (res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] l2;
    int x0, x1, x2, x3;
    int exp_x;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Floor division: the mean rounded toward minus infinity.
  function automatic int fdiv(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic int rnd18();
    logic signed [17:0] r;
    r = 18'($urandom);
    return int'(r);
  endfunction

  function automatic int ax(); return int'($signed(res.avg_x)); endfunction
  function automatic int ay(); return int'($signed(res.avg_y)); endfunction
  function automatic int cnt(); return int'(res.sample_cnt); endfunction

  task automatic pulse(input int x, input int y);
    sensor_data_x = 18'(x);
    sensor_data_y = 18'(y);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    res.ack = 1'b1;
    @(negedge clk);
    res.ack = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int xa[4];
    int n, sx, sy, eff, x, y, mv, mo;
`ifdef EDDY_ACCUM_MINMAX_EN
    int mnx, mxx, mny, mxy;
`endif
    vecs[0] = '{3'd2, 100, 101, 102, 103, 101};
    vecs[1] = '{3'd1, -1, -2, 0, 0, -2};
    vecs[2] = '{3'd0, 5, 0, 0, 0, 5};
    vecs[3] = '{3'd0, -131072, 0, 0, 0, -131072};
    vecs[4] = '{3'd2, 131071, 131071, 131071, 131071, 131071};
    vecs[5] = '{3'd2, -131072, -131072, -131072, -131072, -131072};
    vecs[6] = '{3'd1, 3, 4, 0, 0, 3};
    vecs[7] = '{3'd2, -5, 0, 0, 0, -2};

    res.ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_avg_x", ax(), 0);
    chk("reset_avg_y", ay(), 0);
    chk("reset_valid", int'(res.avg_valid), 0);
    chk("reset_overrun", int'(res.overrun), 0);
    chk("reset_cnt", cnt(), 0);

    // Result latency: done_in captured at edge k, result visible after edge k+1.
    enable = 1'b1;
    avg_log2 = 3'd0;
    repeat (2) @(negedge clk);
    sensor_data_x = 18'(77);
    sensor_data_y = 18'(-3);
    done_in = 1'b1;
    @(negedge clk);
    chk("lat_valid_edge_k", int'(res.avg_valid), 0);
    done_in = 1'b0;
    @(negedge clk);
    chk("lat_valid_edge_k1", int'(res.avg_valid), 1);
    chk("lat_avg_x", ax(), 77);
    chk("lat_avg_y", ay(), -3);

    for (int i = 0; i < 8; i++) begin
      avg_log2 = vecs[i].l2;
      ack_pulse();
      xa[0] = vecs[i].x0; xa[1] = vecs[i].x1; xa[2] = vecs[i].x2; xa[3] = vecs[i].x3;
      n = 1 << vecs[i].l2;
      sy = 0;
      for (int j = 0; j < n; j++) begin
        pulse(xa[j], ~xa[j]);
        sy += ~xa[j];
      end
      $display("vector %0d: log2=%0d", i, vecs[i].l2);
      chk("vec_avg_x", ax(), vecs[i].exp_x);
      chk("vec_avg_y", ay(), fdiv(sy, n));
      chk("vec_valid", int'(res.avg_valid), 1);
      chk("vec_overrun", int'(res.overrun), 0);
      chk("vec_cnt", cnt(), 0);
    end

    // Overrun on unread result, then ack coinciding with the final sample.
    avg_log2 = 3'd1;
    ack_pulse();
    pulse(10, 0); pulse(20, 0);
    chk("ovr_first_valid", int'(res.avg_valid), 1);
    pulse(30, 0); pulse(40, 0);
    chk("ovr_set", int'(res.overrun), 1);
    chk("ovr_avg_second", ax(), 35);
    clear_pulse();
    chk("clear_valid", int'(res.avg_valid), 0);
    chk("clear_overrun", int'(res.overrun), 0);
    chk("clear_keeps_avg", ax(), 35);
    pulse(1, 0); pulse(3, 0);
    pulse(5, 0);
    sensor_data_x = 18'(7);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    res.ack = 1'b1;
    @(negedge clk);
    res.ack = 1'b0;
    chk("ack_final_overrun", int'(res.overrun), 0);
    chk("ack_final_valid", int'(res.avg_valid), 1);
    chk("ack_final_avg", ax(), 6);

    // Exponent change mid-window discards the partial window.
    avg_log2 = 3'd3;
    ack_pulse();
    for (int j = 0; j < 5; j++) pulse(1000, 0);
    chk("chg_cnt_before", cnt(), 5);
    avg_log2 = 3'd2;
    @(negedge clk);
    chk("chg_cnt_after", cnt(), 0);
    pulse(8, 0); pulse(9, 0); pulse(10, 0); pulse(11, 0);
    chk("chg_avg", ax(), 9);
    chk("chg_valid", int'(res.avg_valid), 1);

    // done_in held high across enable rise, then clear mid-window.
    enable = 1'b0;
    @(negedge clk);
    done_in = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_cnt", cnt(), 0);
    done_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_cnt_after", cnt(), 0);
    avg_log2 = 3'd3;
    pulse(1, 0); pulse(1, 0); pulse(1, 0);
    chk("mid_cnt", cnt(), 3);
    clear_pulse();
    chk("mid_clear_cnt", cnt(), 0);
    chk("mid_clear_valid", int'(res.avg_valid), 0);
    for (int j = 0; j < 8; j++) pulse(2, -9);
    chk("after_clear_avg_x", ax(), 2);
    chk("after_clear_avg_y", ay(), -9);

`ifdef EDDY_ACCUM_MINMAX_EN
    avg_log2 = 3'd2;
    ack_pulse();
    pulse(5, 1); pulse(-7, 2); pulse(9, 3); pulse(0, 4);
    chk("mm_min_x", int'($signed(res.min_x)), -7);
    chk("mm_max_x", int'($signed(res.max_x)), 9);
    chk("mm_min_y", int'($signed(res.min_y)), 1);
    chk("mm_max_y", int'($signed(res.max_y)), 4);
    chk("mm_avg_x", ax(), 1);
`endif

    // Random windows against a mean/flag model.
    clear_pulse();
    mv = 0;
    mo = 0;
    for (int w = 0; w < 60; w++) begin
      avg_log2 = 3'($urandom_range(0, 7));
      eff = (int'(avg_log2) > 4) ? 4 : int'(avg_log2);
      n = 1 << eff;
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        mv = 0;
      end
      sx = 0;
      sy = 0;
`ifdef EDDY_ACCUM_MINMAX_EN
      mnx = 0; mxx = 0; mny = 0; mxy = 0;
`endif
      for (int j = 0; j < n; j++) begin
        x = rnd18();
        y = rnd18();
        sx += x;
        sy += y;
`ifdef EDDY_ACCUM_MINMAX_EN
        if (j == 0 || x < mnx) mnx = x;
        if (j == 0 || x > mxx) mxx = x;
        if (j == 0 || y < mny) mny = y;
        if (j == 0 || y > mxy) mxy = y;
`endif
        pulse(x, y);
        if (j == 0 && n > 1) chk("rnd_cnt_first", cnt(), 1);
      end
      if (mv == 1) mo = 1;
      mv = 1;
      $display("window %0d: N=%0d", w, n);
      chk("rnd_avg_x", ax(), fdiv(sx, n));
      chk("rnd_avg_y", ay(), fdiv(sy, n));
      chk("rnd_valid", int'(res.avg_valid), mv);
      chk("rnd_overrun", int'(res.overrun), mo);
      chk("rnd_cnt_end", cnt(), 0);
`ifdef EDDY_ACCUM_MINMAX_EN
      chk("rnd_min_x", int'($signed(res.min_x)), mnx);
      chk("rnd_max_x", int'($signed(res.max_x)), mxx);
      chk("rnd_min_y", int'($signed(res.min_y)), mny);
      chk("rnd_max_y", int'($signed(res.max_y)), mxy);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eddy_sample_accumulator.md
# eddy_sample_accumulator

Downstream consumer of the eddy current sensor SPI master. It captures each completed 18-bit X/Y sample pair on the rising edge of the master's `done`, sums a configurable power-of-two number of pairs, and publishes the block average to the AXI register layer. It uses a sticky valid/acknowledge handshake and flags overruns.

## Interface
- `DATA_W`, default 18, sample width (two's complement, AD4011 format).
- `MAX_LOG2_N`, default 4, largest averaging exponent (N up to 16).

- `clk`  in  1  system clock (200 MHz AXI clock).
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `done_in`  in  1  SPI master `done` level; a rising edge marks a new valid sample pair.
- `sensor_data_x`, `sensor_data_y`  in  DATA_W each  raw samples; stable while `done_in` is high.
- `enable`  in  1  accumulation enable (AXI control register).
- `clear`  in  1  single-cycle pulse; aborts the current window and clears `avg_valid` and `overrun`.
- `avg_log2`  in  3  averaging exponent; N = 2^avg_log2; values above MAX_LOG2_N are clamped.
- `ack`  in  1  single-cycle pulse from the AXI read of the result; clears `avg_valid`.
- `avg_x`, `avg_y`  out  DATA_W each  averaged result, signed.
- `avg_valid`  out  1  sticky; high when an unread result is present.
- `overrun`  out  1  sticky; a result was overwritten while still unread.
- `sample_cnt`  out  MAX_LOG2_N+1  number of samples accumulated in the current window.

## Operation
- FSM states:
  - IDLE: entered on `rst`, on `clear`, or while `enable`=0. In IDLE, `acc` and `sample_cnt` are held at 0.
  - ACCUM: entered when `enable`=1.
- Edge detect:
  - `done_d` is a register holding `done_in`.
  - `sample_ev = done_in & ~done_d`.
  - `done_d` updates in every state. A `done_in` that is already high when ACCUM is entered therefore does not create an event.
- On `sample_ev` in ACCUM, when `sample_cnt` < N-1:
  - `acc_x += sext(sensor_data_x)`, and likewise for `acc_y`.
  - `sample_cnt` increments by 1.
- On `sample_ev` in ACCUM, when `sample_cnt` == N-1 (the final sample of the window):
  - `avg_* <= (acc_* + sample) >>> log2`. This is an arithmetic shift, so it truncates toward −∞.
  - `acc` and `sample_cnt` return to 0.
  - `avg_valid` is set.
  - If `avg_valid` was already 1 and `ack` is not asserted in the same cycle, `overrun` is set.
- Accumulator width: ACC_W = DATA_W + MAX_LOG2_N = 22, signed. Overflow is impossible by construction.
- N=1 (`avg_log2`=0): every sample completes a window, so `avg_*` equals the raw sample.
- A change of `avg_log2` while `sample_cnt` ≠ 0:
  - The current window is discarded: `acc` and `sample_cnt` go to 0.
  - The triggering sample (if any in that cycle) is also discarded.
  - The next window starts at the next `sample_ev`.
- Priority, highest first: `rst` > `clear` > `enable`=0 > `avg_log2` change > `sample_ev`.
- Simultaneous events:
  - `ack` in the same cycle as a final sample: `avg_valid` stays 1 and `overrun` is not set.
  - `ack` alone: `avg_valid` goes to 0.
- `avg_x`/`avg_y` change only on a final sample. They are untouched by `clear` and `enable`.
- Reset values: `avg_x`, `avg_y`, `avg_valid`, `overrun`, `sample_cnt`, `acc`, `done_d` all 0; state IDLE.

## Timing
- Result latency: if `done_in` is first sampled high at clock edge k, then `avg_*` and `avg_valid` are updated at edge k+1.
- All outputs are registered; there are no combinational paths from input to output.
- `done_in` must be low for at least 1 cycle between samples. The master guarantees this, since IDLE→CNV clears `done` more than 64 cycles before the next RX completes.
- `ack` and `clear` are single-cycle. Holding either high only repeats its effect; no other behaviour changes.

## Configuration
- `EDDY_ACCUM_MINMAX_EN` defined:
  - Adds outputs `min_x`, `max_x`, `min_y`, `max_y` (DATA_W each, signed).
  - These track the per-window extremes and are published alongside `avg_*` at the final sample.
  - The first sample of each window initialises the running min and max.
  - Reset value of all four outputs is 0.
- Not defined: these ports and all their logic are absent. Everything else is identical.

## Structure
- Package `eddy_accum_pkg` holds:
  - DATA_W, MAX_LOG2_N, ACC_W;
  - the state enum {IDLE, ACCUM}.
- Sub-module `eddy_accum_channel` is instantiated once for X and once for Y.
  - It contains the accumulator, the shift, the result register and the optional min/max logic.
  - The FSM, edge detect, `sample_cnt` and handshake flags live in the top level.

## Test plan
- `avg_log2`=2, four `done_in` pulses with x=100, 101, 102, 103 → `avg_x`=101 and `avg_valid`=1 at one clock after the 4th edge.
- `avg_log2`=1, x=−1 then −2 (0x3FFFF, 0x3FFFE) → `avg_x`=−2 (0x3FFFE), confirming truncation toward −∞.
- Two full windows with no `ack` → `overrun`=1 and `avg_*` hold the second result. Repeat with `ack` on the same cycle as the final sample → `overrun`=0.
- `avg_log2` changed from 3 to 2 after 5 samples → `sample_cnt`=0, and the next result is the mean of the next 4 samples only.
- `done_in` held high while `enable` rises; `clear` mid-window at `sample_cnt`=3 → no sample counted from the held level; `sample_cnt`=0 and `avg_valid`=0 after `clear`.
- With `EDDY_ACCUM_MINMAX_EN`, N=4, x=5, −7, 9, 0 → `min_x`=−7 and `max_x`=9.
